// File: rtl/stream_mux_rr_if.sv
// Bundle for the N-to-1 stream mux: N producer channels, force-select control, one registered consumer port.
interface stream_mux_rr_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int IDW   = (N > 1) ? $clog2(N) : 1
);
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               sel_force_en;
  logic [IDW-1:0]     sel_force;
  logic [WIDTH-1:0]   out_data;
  logic [IDW-1:0]     out_src;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_data, in_valid, sel_force_en, sel_force, out_ready,
    input  in_ready, out_data, out_src, out_valid
  );

  modport slave (
    input  in_data, in_valid, sel_force_en, sel_force, out_ready,
    output in_ready, out_data, out_src, out_valid
  );
endinterface

// File: rtl/stream_mux_rr.sv
// Registered N:1 stream mux with round-robin or fixed-priority arbitration and optional forced select.
// Latency: one cycle from input transfer to out_valid; one word per cycle while out_ready is high.
// Backpressure: all in_ready drop while a held word is stalled; a draining word is replaced in the same edge.
module stream_mux_rr #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int MODE  = 0
) (
  input logic             clk,
  input logic             rst_n,
  stream_mux_rr_if.slave  bus
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   grant;
  logic             grant_vld;
  logic             load_en;
  logic [WIDTH-1:0] sel_data;
  int               idx;

  always_comb begin
    load_en   = !bus.out_valid || bus.out_ready;
    grant_vld = 1'b0;
    grant     = '0;
    idx       = 0;
    if (bus.sel_force_en) begin
      // An out-of-range force index yields no grant rather than aliasing onto a real channel.
      if (int'(bus.sel_force) < N) begin
        if (bus.in_valid[bus.sel_force]) begin
          grant_vld = 1'b1;
          grant     = bus.sel_force;
        end
      end
    end else if (MODE == 1) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (bus.in_valid[k]) begin
          grant_vld = 1'b1;
          grant     = IDW'(k);
        end
      end
    end else begin
      // Scan downward so the channel nearest the pointer is the last, winning, assignment.
      for (int k = N - 1; k >= 0; k--) begin
        idx = int'(ptr) + k;
        if (idx >= N) idx = idx - N;
        if (bus.in_valid[idx]) begin
          grant_vld = 1'b1;
          grant     = IDW'(idx);
        end
      end
    end
  end

  assign sel_data = bus.in_data[int'(grant)*WIDTH +: WIDTH];

  always_comb begin
    bus.in_ready = '0;
    if (rst_n && load_en && grant_vld) bus.in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_src   <= '0;
      ptr           <= '0;
    end else if (load_en) begin
      bus.out_valid <= grant_vld;
      if (grant_vld) begin
        bus.out_data <= sel_data;
        bus.out_src  <= grant;
        ptr          <= (int'(grant) == N - 1) ? '0 : grant + IDW'(1);
      end
    end
  end
endmodule
